// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM states, ACK levels and R/W bit encodings.
`timescale 1ns/1ps
package i2c_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    PTR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    RDATA_ACK,
    WAIT_STOP
  } state_t;

  localparam logic ACK      = 1'b0;
  localparam logic NACK     = 1'b1;
  localparam logic RW_WRITE = 1'b0;
  localparam logic RW_READ  = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA synchronizer with edge and START/STOP detection.
// Optional I2C_SLV_GLITCH_FILTER_EN adds a 3-sample consistency filter after the synchronizer.
`timescale 1ns/1ps
module i2c_line_sync (
  input  logic clk,
  input  logic reset,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic [1:0] scl_meta;
  logic [1:0] sda_meta;
  logic       scl_lvl;
  logic       sda_lvl;
  logic       scl_d;
  logic       sda_d;

  // Reset to the idle-bus level so releasing reset never looks like START/STOP.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_meta <= '1;
      sda_meta <= '1;
    end else begin
      scl_meta <= {scl_meta[0], scl_i};
      sda_meta <= {sda_meta[0], sda_i};
    end
  end

`ifdef I2C_SLV_GLITCH_FILTER_EN
  logic [1:0] scl_hist;
  logic [1:0] sda_hist;
  logic       scl_f;
  logic       sda_f;

  // Level follows the input only after three consecutive equal samples.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_meta[1]};
      sda_hist <= {sda_hist[0], sda_meta[1]};
      if (scl_meta[1] == scl_hist[0] && scl_hist[0] == scl_hist[1]) scl_f <= scl_meta[1];
      if (sda_meta[1] == sda_hist[0] && sda_hist[0] == sda_hist[1]) sda_f <= sda_meta[1];
    end
  end

  assign scl_lvl = scl_f;
  assign sda_lvl = sda_f;
`else
  assign scl_lvl = scl_meta[1];
  assign sda_lvl = sda_meta[1];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_d <= 1'b1;
      sda_d <= 1'b1;
    end else begin
      scl_d <= scl_lvl;
      sda_d <= sda_lvl;
    end
  end

  assign scl_rise  = scl_lvl & ~scl_d;
  assign scl_fall  = ~scl_lvl & scl_d;
  assign start_det = scl_lvl & scl_d & sda_d & ~sda_lvl;
  assign stop_det  = scl_lvl & scl_d & ~sda_d & sda_lvl;
  assign sda_s     = sda_lvl;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C target exposing a pointer-addressed synchronous register bus.
// Build option I2C_SLV_GLITCH_FILTER_EN enables input glitch filtering in i2c_line_sync.
`timescale 1ns/1ps
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = 7'h50,
  parameter int unsigned PTR_W      = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic [PTR_W-1:0] reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_wr,
  output logic             reg_rd,
  input  logic [7:0]       reg_rdata,
  output logic             busy
);

  logic       scl_rise;
  logic       scl_fall;
  logic       start_det;
  logic       stop_det;
  logic       sda_s;

  state_t     state;
  state_t     state_next;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       rw;
  logic [7:0] rx_byte;
  logic       last_bit;
  logic       addr_hit;

  i2c_line_sync u_sync (
    .clk       (clk),
    .reset     (reset),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  assign rx_byte  = {shift[6:0], sda_s};
  assign last_bit = (bit_cnt == 3'd7);
  assign addr_hit = (rx_byte[7:1] == SLAVE_ADDR);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // In the ACK states sda_oe doubles as the phase flag: 0 = ACK not yet driven.
  always_comb begin
    state_next = state;
    reg_rd     = 1'b0;
    if (stop_det) begin
      state_next = IDLE;
    end else if (start_det) begin
      state_next = ADDR;
    end else begin
      case (state)
        ADDR:      if (scl_rise && last_bit) state_next = addr_hit ? ADDR_ACK : IDLE;
        ADDR_ACK:  if (scl_fall && sda_oe) begin
                     if (rw == RW_WRITE) begin
                       state_next = PTR;
                     end else begin
                       reg_rd     = 1'b1;
                       state_next = RDATA;
                     end
                   end
        PTR:       if (scl_rise && last_bit) state_next = PTR_ACK;
        PTR_ACK,
        WDATA_ACK: if (scl_fall && sda_oe) state_next = WDATA;
        WDATA:     if (scl_rise && last_bit) state_next = WDATA_ACK;
        RDATA:     if (scl_fall && last_bit) state_next = RDATA_ACK;
        RDATA_ACK: if (scl_rise && sda_s == NACK) begin
                     state_next = WAIT_STOP;
                   end else if (scl_fall) begin
                     reg_rd     = 1'b1;
                     state_next = RDATA;
                   end
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sda_oe    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= '0;
      reg_wr    <= 1'b0;
      busy      <= 1'b0;
      shift     <= '0;
      bit_cnt   <= '0;
      rw        <= RW_WRITE;
    end else begin
      reg_wr <= 1'b0;
      if (reg_wr) reg_addr <= reg_addr + PTR_W'(1);

      if (stop_det) begin
        sda_oe  <= 1'b0;
        busy    <= 1'b0;
        bit_cnt <= '0;
      end else if (start_det) begin
        sda_oe  <= 1'b0;
        bit_cnt <= '0;
      end else begin
        case (state)
          ADDR, PTR, WDATA: if (scl_rise) begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              if (state == ADDR) begin
                busy <= addr_hit;
                rw   <= rx_byte[0];
              end
              if (state == PTR) reg_addr <= PTR_W'(rx_byte);
              if (state == WDATA) begin
                reg_wdata <= rx_byte;
                reg_wr    <= 1'b1;
              end
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: if (scl_fall) begin
            if (!sda_oe) begin
              sda_oe <= ~ACK;
            end else if (state == ADDR_ACK && rw == RW_READ) begin
              shift   <= reg_rdata;
              sda_oe  <= ~reg_rdata[7];
              bit_cnt <= '0;
            end else begin
              sda_oe <= 1'b0;
            end
          end
          RDATA: if (scl_fall) begin
            bit_cnt <= bit_cnt + 3'd1;
            if (last_bit) begin
              sda_oe   <= 1'b0;
              reg_addr <= reg_addr + PTR_W'(1);
            end else begin
              shift  <= {shift[6:0], 1'b0};
              sda_oe <= ~shift[6];
            end
          end
          // Only reachable after an ACK was sampled; NACK leaves on the rising edge.
          RDATA_ACK: if (scl_fall) begin
            shift   <= reg_rdata;
            sda_oe  <= ~reg_rdata[7];
            bit_cnt <= '0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
